// File: rtl/ddr3_pkg.sv
// Shared types and constants for the DDR3 read/write arbiter.
package ddr3_pkg;

  localparam int ADDR_W = 28;
  localparam int CNT_W  = 10;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_WRITE,
    ST_READ,
    ST_RD_WAIT
  } state_t;

  // Place the ping-pong bank select onto its address bit.
  function automatic logic [ADDR_W-1:0] with_bank(input logic [ADDR_W-1:0] off,
                                                  input logic              bank,
                                                  input int                bit_pos);
    logic [ADDR_W-1:0] r;
    r          = off;
    r[bit_pos] = bank;
    return r;
  endfunction

endpackage

// File: rtl/ddr3_load_sync.sv
// Two-flop synchroniser for an asynchronous frame-load level, followed by a
// single-cycle rising-edge pulse.
module ddr3_load_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  output logic o_pulse
);

  logic r_meta, r_sync, r_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_level;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/ddr3_rw_arbiter.sv
// MIG user-side arbiter: drains write bursts to DDR3 and refills the read FIFO.
// Optional macro DDR3_PINGPONG_EN enables two frame banks selected by app_addr[BANK_BIT].
module ddr3_rw_arbiter
  import ddr3_pkg::*;
#(
  parameter int APP_ADDR_MIN = 0,
  parameter int APP_ADDR_MAX = 1024*768*2/2,
  parameter int BURST_LEN    = 64,
  parameter int ADDR_STEP    = 8,
  parameter int RD_THRESH    = 64,
  parameter int BANK_BIT     = 24
) (
  input  logic              ui_clk,
  input  logic              rst,
  input  logic              init_calib_complete,
  input  logic              app_rdy,
  input  logic              app_wdf_rdy,
  input  logic              app_rd_data_valid,
  input  logic [255:0]      app_rd_data,
  input  logic [CNT_W-1:0]  wfifo_rcount,
  input  logic [CNT_W-1:0]  rfifo_wcount,
  input  logic              wr_load,
  input  logic              rd_load,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic              wfifo_rden,
  output logic              rfifo_wren,
  output logic [255:0]      rfifo_din
);

  localparam logic [ADDR_W-1:0] L_MIN  = ADDR_W'(APP_ADDR_MIN);
  localparam logic [ADDR_W-1:0] L_MAX  = ADDR_W'(APP_ADDR_MAX);
  localparam logic [ADDR_W-1:0] L_STEP = ADDR_W'(ADDR_STEP);
  localparam logic [7:0]        L_BL   = 8'(BURST_LEN);
  localparam logic [CNT_W-1:0]  L_BL_C = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  L_THR  = CNT_W'(RD_THRESH);

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_off, r_rd_off;
  logic [7:0]        r_beat, r_issued, r_returned;
  logic              r_wr_pend, r_rd_pend;
  logic              w_wr_pulse, w_rd_pulse;
  logic              w_accept, w_in_arb, w_wr_apply, w_rd_apply;
  logic [ADDR_W-1:0] w_wr_inc, w_rd_inc, w_wr_next, w_rd_next;
  logic              w_wr_bank, w_rd_bank;

  ddr3_load_sync u_wr_sync (.i_clk(ui_clk), .i_rst(rst), .i_level(wr_load), .o_pulse(w_wr_pulse));
  ddr3_load_sync u_rd_sync (.i_clk(ui_clk), .i_rst(rst), .i_level(rd_load), .o_pulse(w_rd_pulse));

  assign w_accept   = app_rdy & app_wdf_rdy;
  assign w_in_arb   = (r_state == ST_IDLE) || (r_state == ST_ARB);
  // Rewinds only between bursts; an edge seen this cycle is applied directly.
  assign w_wr_apply = w_in_arb & (r_wr_pend | w_wr_pulse);
  assign w_rd_apply = w_in_arb & (r_rd_pend | w_rd_pulse);

  assign w_wr_inc  = r_wr_off + L_STEP;
  assign w_rd_inc  = r_rd_off + L_STEP;
  assign w_wr_next = (w_wr_inc >= L_MAX) ? L_MIN : w_wr_inc;
  assign w_rd_next = (w_rd_inc >= L_MAX) ? L_MIN : w_rd_inc;

`ifdef DDR3_PINGPONG_EN
  logic r_wr_bank, r_rd_bank;

  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      if (w_wr_apply) r_wr_bank <= ~r_wr_bank;
      // Read the bank the writer has just finished, i.e. not the one it moves to.
      if (w_rd_apply) r_rd_bank <= ~(r_wr_bank ^ w_wr_apply);
    end
  end

  assign w_wr_bank = r_wr_bank;
  assign w_rd_bank = r_rd_bank;
`else
  assign w_wr_bank = 1'b0;
  assign w_rd_bank = 1'b0;
`endif

  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wr_off   <= L_MIN;
      r_rd_off   <= L_MIN;
      r_beat     <= '0;
      r_issued   <= '0;
      r_returned <= '0;
      r_wr_pend  <= 1'b0;
      r_rd_pend  <= 1'b0;
    end else begin
      if (w_wr_apply)      r_wr_pend <= 1'b0;
      else if (w_wr_pulse) r_wr_pend <= 1'b1;
      if (w_rd_apply)      r_rd_pend <= 1'b0;
      else if (w_rd_pulse) r_rd_pend <= 1'b1;
      if (w_wr_apply) r_wr_off <= L_MIN;
      if (w_rd_apply) r_rd_off <= L_MIN;

      case (r_state)
        ST_IDLE: if (init_calib_complete) r_state <= ST_ARB;
        ST_ARB: begin
          if (wfifo_rcount >= L_BL_C) begin
            r_state <= ST_WRITE;
            r_beat  <= '0;
          end else if (rfifo_wcount < L_THR) begin
            r_state    <= ST_READ;
            r_issued   <= '0;
            r_returned <= '0;
          end
        end
        ST_WRITE: if (w_accept) begin
          r_beat   <= r_beat + 8'd1;
          r_wr_off <= w_wr_next;
          if (r_beat == L_BL - 8'd1) r_state <= ST_ARB;
        end
        ST_READ: if (app_rdy) begin
          r_issued <= r_issued + 8'd1;
          r_rd_off <= w_rd_next;
          if (r_issued == L_BL - 8'd1) r_state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: if (r_returned == L_BL) r_state <= ST_ARB;
        default: r_state <= ST_IDLE;
      endcase

      if (((r_state == ST_READ) || (r_state == ST_RD_WAIT)) && app_rd_data_valid)
        r_returned <= r_returned + 8'd1;
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    app_en       = 1'b0;
    app_cmd      = APP_CMD_WR;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    wfifo_rden   = 1'b0;
    app_addr     = with_bank(r_rd_off, w_rd_bank, BANK_BIT);
    case (r_state)
      ST_WRITE: begin
        app_en       = w_accept;
        app_wdf_wren = w_accept;
        app_wdf_end  = w_accept;
        wfifo_rden   = w_accept;
        app_addr     = with_bank(r_wr_off, w_wr_bank, BANK_BIT);
      end
      ST_READ: begin
        app_en  = app_rdy;
        app_cmd = APP_CMD_RD;
      end
      default: ;
    endcase
  end

  assign rfifo_wren = app_rd_data_valid;
  assign rfifo_din  = app_rd_data;

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// Directed bench for ddr3_rw_arbiter, built with a 1024-word address window so
// pointer wrap is reachable; expectations follow DDR3_PINGPONG_EN when defined.
module tb_ddr3_rw_arbiter;
  import ddr3_pkg::*;

  logic              ui_clk = 1'b0;
  logic              rst;
  logic              init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data_valid;
  logic [255:0]      app_rd_data;
  logic [CNT_W-1:0]  wfifo_rcount, rfifo_wcount;
  logic              wr_load, rd_load;
  logic              app_en, app_wdf_wren, app_wdf_end, wfifo_rden, rfifo_wren;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic [255:0]      rfifo_din;

  int n_cmp = 0;
  int n_mis = 0;

`ifdef DDR3_PINGPONG_EN
  localparam logic [ADDR_W-1:0] WR_BANK_AFTER_LOAD = 28'h100_0000;
`else
  localparam logic [ADDR_W-1:0] WR_BANK_AFTER_LOAD = 28'h000_0000;
`endif

  ddr3_rw_arbiter #(.APP_ADDR_MAX(1024)) dut (
    .ui_clk(ui_clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data(app_rd_data), .wfifo_rcount(wfifo_rcount), .rfifo_wcount(rfifo_wcount),
    .wr_load(wr_load), .rd_load(rd_load), .app_en(app_en), .app_cmd(app_cmd),
    .app_addr(app_addr), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .wfifo_rden(wfifo_rden), .rfifo_wren(rfifo_wren), .rfifo_din(rfifo_din)
  );

  always #5 ui_clk = ~ui_clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge ui_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int b, stall, cyc, pops;
    logic [255:0] data;

    rst = 1'b1; init_calib_complete = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    app_rd_data_valid = 1'b0; app_rd_data = '0; wfifo_rcount = 10'd200;
    rfifo_wcount = 10'd64; wr_load = 1'b0; rd_load = 1'b0;
    #1;
    check("rst_app_en", app_en, 0);
    check("rst_app_addr", app_addr, 0);
    check("rst_wfifo_rden", wfifo_rden, 0);
    check("rst_app_wdf_wren", app_wdf_wren, 0);
    check("rst_app_cmd", app_cmd, 0);
    tick(); tick();
    rst = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;

    // No command may leave before calibration, even with a full write FIFO.
    repeat (4) begin
      tick();
      check("calib_gate", app_en, 0);
    end
    init_calib_complete = 1'b1; wfifo_rcount = 10'd64;
    tick();
    check("calib_arb_cycle", app_en, 0);
    tick();
    check("calib_first_write", app_en, 1);

    wfifo_rcount = 10'd0;
    for (int i = 0; i < 64; i++) begin
      settle();
      check("wr_en", app_en, 1);
      check("wr_rden", wfifo_rden, 1);
      check("wr_end", app_wdf_end, 1);
      check("wr_cmd", app_cmd, 3'b000);
      check("wr_addr", app_addr, i * 8);
      tick();
    end
    check("wr_done_idle", app_en, 0);
    tick();
    check("arb_rd_thresh_boundary", app_en, 0);

    rfifo_wcount = 10'd63;
    tick();
    rfifo_wcount = 10'd64;
    for (int i = 0; i < 64; i++) begin
      settle();
      check("rd_en", app_en, 1);
      check("rd_cmd", app_cmd, 3'b001);
      check("rd_addr", app_addr, i * 8);
      tick();
    end
    check("rd_wait_en", app_en, 0);

    // A pending write must not pre-empt the outstanding read returns.
    wfifo_rcount = 10'd64;
    for (int i = 0; i < 64; i++) begin
      data = {8{32'hA500_0000 + 32'(i)}};
      app_rd_data_valid = 1'b1; app_rd_data = data;
      settle();
      check("ret_wren", rfifo_wren, 1);
      check("ret_din", rfifo_din, data);
      check("ret_hold", app_en, 0);
      tick();
      app_rd_data_valid = 1'b0;
      settle();
      check("ret_wren_low", rfifo_wren, 0);
      tick();
    end
    check("rd_wait_to_arb", app_en, 0);
    tick();
    check("bp_first_en", app_en, 1);
    check("bp_first_addr", app_addr, 512);

    wfifo_rcount = 10'd0;
    b = 0; stall = 0; cyc = 0; pops = 0;
    while (b < 64 && cyc < 100) begin
      if (b == 10 && stall < 5) begin
        app_wdf_rdy = 1'b0;
        stall++;
      end else begin
        app_wdf_rdy = 1'b1;
      end
      settle();
      check("bp_en", app_en, app_wdf_rdy);
      check("bp_addr", app_addr, 512 + b * 8);
      if (wfifo_rden) pops++;
      if (app_wdf_rdy) b++;
      tick();
      cyc++;
    end
    app_wdf_rdy = 1'b1;
    check("bp_pops", pops, 64);
    check("bp_cycles", cyc, 69);
    check("bp_done", app_en, 0);

    // Pointer wraps past 1016 back to 0; a mid-burst load waits for the burst end.
    wfifo_rcount = 10'd64;
    tick();
    wfifo_rcount = 10'd0;
    for (int i = 0; i < 64; i++) begin
      if (i == 30) wr_load = 1'b1;
      settle();
      check("wrap_addr", app_addr, i * 8);
      check("wrap_en", app_en, 1);
      tick();
    end
    tick(); tick();
    wr_load = 1'b0; wfifo_rcount = 10'd64;
    tick();
    wfifo_rcount = 10'd0;
    for (int i = 0; i < 64; i++) begin
      settle();
      check("load_addr", app_addr, WR_BANK_AFTER_LOAD | ADDR_W'(i * 8));
      tick();
    end
    check("load_done", app_en, 0);

    rd_load = 1'b1;
    repeat (4) tick();
    rd_load = 1'b0;
    tick();
    rfifo_wcount = 10'd0;
    tick();
    check("rd_load_en", app_en, 1);
    check("rd_load_cmd", app_cmd, 3'b001);
    check("rd_load_addr", app_addr, 0);
    tick(); tick(); tick();
    check("rd_load_addr3", app_addr, 24);

    // Asynchronous reset mid-burst returns outputs immediately.
    rst = 1'b1;
    settle();
    check("midrst_en", app_en, 0);
    check("midrst_addr", app_addr, 0);
    check("midrst_cmd", app_cmd, 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_arb", app_en, 0);
    tick();
    check("post_rst_rd_en", app_en, 1);
    check("post_rst_rd_addr", app_addr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
